// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and line levels for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_calc8.sv
// rtl/parity_calc8.sv - combinational byte parity, even or odd
module parity_calc8
    import uart_pkg::*;
(
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 odd_i,
    output logic                 parity_o
);

    assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - byte-in UART transmitter with parity and 1/2 stop bits
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       parity_out
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t          state_q;
    logic [BW-1:0]        baud_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 ready_q;
    logic                 parity_q;
    logic                 parity_d;
    logic                 baud_done;

    parity_calc8 u_parity (
        .data_i   (data_in),
        .odd_i    (PARITY_ODD),
        .parity_o (parity_d)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    // Outputs are all registered; the async reset forces the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            parity_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (data_valid && ready_q) begin
                state_q   <= START;
                shift_q   <= data_in;
                parity_q  <= parity_d;
                tx_q      <= START_LEVEL;
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
                baud_q    <= '0;
                bit_idx_q <= '0;
            end
        end else begin
            baud_q <= baud_done ? '0 : baud_q + 1'b1;
            if (baud_done) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_idx_q == DATA_LAST) begin
                            state_q   <= PARITY;
                            tx_q      <= parity_q;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        tx_q    <= STOP_LEVEL;
                    end
                    STOP: begin
                        if (bit_idx_q == STOP_LAST) begin
                            state_q   <= IDLE;
                            tx_q      <= IDLE_LEVEL;
                            busy_q    <= 1'b0;
                            ready_q   <= 1'b1;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign data_ready = ready_q;
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign parity_out = parity_q;

endmodule
